vram_port_arbiter: RTL and testbench
====================================

// Module: vram_port_arbiter
// PURPOSE
//  Shares one single-port framebuffer RAM port between the CPU data bus and the display pixel stream.
//  Display reads are prefetched in linear address order into a small FIFO that the VGA side pops.
//  The CPU gets the port whenever display demand is not urgent.
//  Sits between cpu/RAM and the VGA pixel path; replaces a free-running scan counter on a second RAM port.
// PARAMETERS
//  ADDR_W      16     RAM word-address width
//  DATA_W      32     RAM word width
//  FB_WORDS    65536  framebuffer size in words; display address wraps FB_WORDS-1 -> 0
//  FIFO_DEPTH  8      pixel prefetch FIFO depth, power of two
//  LOW_WATER   2      occupancy (stored + in flight) at or below which display has priority
// PORTS
//  clk        in   1       single clock for CPU, RAM and pixel side
//  reset      in   1       asynchronous, active-high
//  cpu_req    in   1       CPU access request; held with stable fields until cpu_ack
//  cpu_we     in   1       1 = write, 0 = read
//  cpu_addr   in   ADDR_W  CPU word address
//  cpu_wdata  in   DATA_W  CPU write data
//  cpu_ack    out  1       one-cycle pulse: access complete
//  cpu_rdata  out  DATA_W  read data, valid while cpu_ack=1 for a read
//  disp_en    in   1       allow display prefetch
//  frame_sync in   1       restart display at address 0 and flush FIFO
//  pix_rd     in   1       pop one pixel word
//  pix_data   out  DATA_W  FIFO head word; 0 when empty
//  pix_valid  out  1       FIFO not empty
//  disp_addr  out  ADDR_W  next display address to fetch
//  mem_addr   out  ADDR_W  RAM address
//  mem_wdata  out  DATA_W  RAM write data
//  mem_we     out  1       RAM write enable
//  mem_rdata  in   DATA_W  RAM read data, one cycle after address (registered RAM)
// BEHAVIOUR
//  Reset: all outputs 0, FIFO empty, disp_addr 0, no read in flight, grant NONE.
//  Grant: one per cycle, from {NONE, CPU, DISP}.
//   - occ = FIFO count + in-flight display read.
//   - Urgent: disp_en and occ <= LOW_WATER -> DISP.
//   - Otherwise cpu_req and no CPU read in flight -> CPU.
//   - Otherwise disp_en and occ < FIFO_DEPTH -> DISP.
//   - Otherwise NONE.
//  CPU write: mem_we=1 and cpu_ack=1 in the grant cycle (zero-wait when granted).
//  CPU read: address issued in cycle N; cpu_ack=1 with cpu_rdata=mem_rdata in N+1.
//   - cpu_req must stay high through N+1.
//   - The CPU is not re-granted in N+1.
//  DISP grant: mem_addr=disp_addr; disp_addr increments (wraps at FB_WORDS-1).
//   - mem_rdata is pushed into the FIFO in the next cycle.
//  FIFO:
//   - pix_rd with pix_valid pops the head.
//   - Push and pop in the same cycle leave the count unchanged.
//   - pix_rd while empty is ignored and counts as underflow.
//  Overflow is impossible by construction (occ < FIFO_DEPTH).
//  frame_sync has highest precedence:
//   - FIFO count to 0, disp_addr to 0, in-flight display read discarded.
//   - No DISP grant in that cycle; a simultaneous pix_rd is ignored.
//   - An in-flight CPU read still completes.
//  disp_en low: no new display fetches; FIFO and disp_addr hold; an in-flight fetch still lands.
//  mem_we is asserted only on a CPU write grant; mem_wdata = cpu_wdata otherwise don't-care.
//  Reset mid-read: in-flight read dropped, no cpu_ack.
// CONFIGURATION
//  VRAM_ARB_STATS_EN defined: adds outputs stat_cpu_wait[31:0] and stat_underflow[31:0].
//   - stat_cpu_wait counts cycles with cpu_req high and no CPU grant (excluding read N+1).
//   - stat_underflow counts pix_rd while empty.
//   - Both saturate at all-ones and reset to 0.
//  Undefined: ports and counters absent; functional behaviour identical.
// STRUCTURE
//  Package vram_pkg: typedef enum logic [1:0] {GNT_NONE, GNT_CPU, GNT_DISP} vram_gnt_e;
//   also ADDR_W/DATA_W defaults and FB_WORDS localparam.
//  Sub-module: vram_pixel_fifo (synchronous FIFO, count output, async reset).
//  Grant logic, in-flight tags and the display address counter stay in the top module.
// TESTING
//  1. Reset, disp_en=1, no pix_rd -> DISP grants at addr 0..7 then stop; pix_valid=1; disp_addr=8.
//  2. FIFO full, CPU write addr 0x0100 data 0xDEADBEEF -> mem_we=1 and cpu_ack in the same cycle;
//     a following CPU read of 0x0100 gives cpu_ack at N+1 with cpu_rdata=0xDEADBEEF.
//  3. pix_rd every cycle with a CPU read held high -> occ<=2 forces DISP grants;
//     CPU still acked within 4 cycles; pix_valid never drops after the initial fill.
//  4. disp_addr=FB_WORDS-1 -> fetch issued at 0xFFFF, next at 0x0000; data order preserved.
//  5. frame_sync while a display read is in flight and pix_rd=1 -> next cycle pix_valid=0, disp_addr=0;
//     the discarded read is not pushed.
//  6. VRAM_ARB_STATS_EN: 3 pops on empty FIFO -> stat_underflow=3;
//     CPU blocked 5 cycles -> stat_cpu_wait=5.

Source files
------------

// File: rtl/vram_port_arbiter_pkg.sv
// Shared types and defaults for the framebuffer port arbiter.
//   vram_gnt_e      : owner of the RAM port in a given cycle
//   VRAM_ADDR_W     : default RAM word-address width
//   VRAM_DATA_W     : default RAM word width
//   VRAM_FB_WORDS   : default framebuffer size in words
//   sat_inc32()     : 32-bit increment that sticks at all-ones
package vram_pkg;

  localparam int unsigned VRAM_ADDR_W   = 16;
  localparam int unsigned VRAM_DATA_W   = 32;
  localparam int unsigned VRAM_FB_WORDS = 65536;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_CPU  = 2'd1,
    GNT_DISP = 2'd2
  } vram_gnt_e;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/vram_pixel_fifo.sv
// Synchronous prefetch FIFO for display pixel words.
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   flush             : empty the FIFO; push and pop in the same cycle are dropped
//   push, push_data   : write one word (caller guarantees not full)
//   pop               : remove head word; ignored while empty
//   head              : head word, 0 when empty
//   valid             : FIFO not empty
//   count             : number of stored words
module vram_pixel_fifo
  import vram_pkg::*;
#(
  parameter int unsigned DATA_W = VRAM_DATA_W,
  parameter int unsigned DEPTH  = 8,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              valid,
  output logic [CNT_W-1:0]  count
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              pop_ok;

  assign valid  = (count != '0);
  assign pop_ok = pop && valid;
  assign head   = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop_ok);
    end
  end

  // Storage carries no reset; only words below count are ever observed.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/vram_port_arbiter.sv
// Shares a single-port registered framebuffer RAM between the CPU bus and a
// linear display prefetch stream feeding the VGA pixel FIFO.
// Optional build macro: VRAM_ARB_STATS_EN adds stat_cpu_wait/stat_underflow.
// Ports:
//   clk, reset                  : clock, asynchronous active-high reset
//   cpu_req/we/addr/wdata       : CPU request, held stable until cpu_ack
//   cpu_ack, cpu_rdata          : completion pulse, read data with the ack
//   disp_en                     : allow display prefetch
//   frame_sync                  : restart display at 0 and flush FIFO
//   pix_rd, pix_data, pix_valid : pixel FIFO pop side
//   disp_addr                   : next display address to fetch
//   mem_addr/wdata/we, mem_rdata: RAM port (read data one cycle after address)
//   stat_cpu_wait, stat_underflow (VRAM_ARB_STATS_EN only): saturating counters
module vram_port_arbiter
  import vram_pkg::*;
#(
  parameter int unsigned ADDR_W     = VRAM_ADDR_W,
  parameter int unsigned DATA_W     = VRAM_DATA_W,
  parameter int unsigned FB_WORDS   = VRAM_FB_WORDS,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned LOW_WATER  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              disp_en,
  input  logic              frame_sync,
  input  logic              pix_rd,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid,
  output logic [ADDR_W-1:0] disp_addr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef VRAM_ARB_STATS_EN
  ,
  output logic [31:0]       stat_cpu_wait,
  output logic [31:0]       stat_underflow
`endif
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned OCC_W = CNT_W + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_WORDS - 1);
  localparam logic [OCC_W-1:0]  LOW_OCC   = OCC_W'(LOW_WATER);
  localparam logic [OCC_W-1:0]  FULL_OCC  = OCC_W'(FIFO_DEPTH);

  vram_gnt_e        gnt;
  vram_gnt_e        gnt_q;
  logic             cpu_we_q;
  logic             disp_inflight;
  logic             cpu_rd_pend;
  logic [CNT_W-1:0] fifo_count;
  logic [OCC_W-1:0] occ;
  logic             disp_ok;
  logic             fifo_push;
  logic             fifo_pop;

  // The previous cycle's grant doubles as the in-flight tag: the RAM returns
  // data exactly one cycle after the address, so only gnt_q can be pending.
  assign disp_inflight = (gnt_q == GNT_DISP);
  assign cpu_rd_pend   = (gnt_q == GNT_CPU) && !cpu_we_q;

  assign occ     = OCC_W'(fifo_count) + OCC_W'(disp_inflight);
  assign disp_ok = disp_en && !frame_sync;

  always_comb begin
    gnt = GNT_NONE;
    if (disp_ok && (occ <= LOW_OCC)) begin
      gnt = GNT_DISP;
    end else if (cpu_req && !cpu_rd_pend) begin
      gnt = GNT_CPU;
    end else if (disp_ok && (occ < FULL_OCC)) begin
      gnt = GNT_DISP;
    end
  end

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    cpu_ack   = 1'b0;
    cpu_rdata = '0;
    unique case (gnt)
      GNT_CPU: begin
        mem_addr = cpu_addr;
        if (cpu_we) begin
          mem_we    = 1'b1;
          mem_wdata = cpu_wdata;
          cpu_ack   = 1'b1;
        end
      end
      GNT_DISP: mem_addr = disp_addr;
      default: ;
    endcase
    if (cpu_rd_pend) begin
      cpu_ack   = 1'b1;
      cpu_rdata = mem_rdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt_q     <= GNT_NONE;
      cpu_we_q  <= 1'b0;
      disp_addr <= '0;
    end else begin
      gnt_q    <= gnt;
      cpu_we_q <= cpu_we;
      if (frame_sync) begin
        disp_addr <= '0;
      end else if (gnt == GNT_DISP) begin
        disp_addr <= (disp_addr == LAST_ADDR) ? '0 : disp_addr + ADDR_W'(1);
      end
    end
  end

  // A display read landing during frame_sync belongs to the old frame.
  assign fifo_push = disp_inflight && !frame_sync;
  assign fifo_pop  = pix_rd && !frame_sync;

  vram_pixel_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (frame_sync),
    .push      (fifo_push),
    .push_data (mem_rdata),
    .pop       (fifo_pop),
    .head      (pix_data),
    .valid     (pix_valid),
    .count     (fifo_count)
  );

`ifdef VRAM_ARB_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_cpu_wait  <= '0;
      stat_underflow <= '0;
    end else begin
      if (cpu_req && (gnt != GNT_CPU) && !cpu_rd_pend)
        stat_cpu_wait <= sat_inc32(stat_cpu_wait);
      if (pix_rd && !pix_valid)
        stat_underflow <= sat_inc32(stat_underflow);
    end
  end
`endif

endmodule

// File: tb/tb_vram_port_arbiter.sv
// Self-checking bench for vram_port_arbiter: vector table for the initial
// display fill, hand sequences for CPU access, urgency, wrap and frame_sync,
// a CPU-ack scoreboard queue and a linear pixel-order model.
module tb_vram_port_arbiter;

  logic        clk;
  logic        reset;
  logic        cpu_req;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_ack;
  logic [31:0] cpu_rdata;
  logic        disp_en;
  logic        frame_sync;
  logic        pix_rd;
  logic [31:0] pix_data;
  logic        pix_valid;
  logic [15:0] disp_addr;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;
`ifdef VRAM_ARB_STATS_EN
  logic [31:0] stat_cpu_wait;
  logic [31:0] stat_underflow;
`endif

  int checks = 0;
  int errors = 0;

  vram_port_arbiter #(
    .ADDR_W     (16),
    .DATA_W     (32),
    .FB_WORDS   (65536),
    .FIFO_DEPTH (8),
    .LOW_WATER  (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_ack    (cpu_ack),
    .cpu_rdata  (cpu_rdata),
    .disp_en    (disp_en),
    .frame_sync (frame_sync),
    .pix_rd     (pix_rd),
    .pix_data   (pix_data),
    .pix_valid  (pix_valid),
    .disp_addr  (disp_addr),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_rdata  (mem_rdata)
`ifdef VRAM_ARB_STATS_EN
    ,
    .stat_cpu_wait  (stat_cpu_wait),
    .stat_underflow (stat_underflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- memory model and expected-content shadow ----------------
  function automatic logic [31:0] pat(input logic [15:0] a);
    return {a ^ 16'hA5A5, a};
  endfunction

  logic [31:0] ram    [int];
  logic [31:0] shadow [int];

  function automatic logic [31:0] exp_word(input int a);
    return shadow.exists(a) ? shadow[a] : pat(16'(a));
  endfunction

  always @(posedge clk) begin : ram_model
    logic [31:0] rd;
    rd = ram.exists(int'(mem_addr)) ? ram[int'(mem_addr)] : pat(mem_addr);
    if (mem_we) ram[int'(mem_addr)] = mem_wdata;
    mem_rdata <= rd;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- CPU ack scoreboard ----------------
  typedef struct {
    logic        is_read;
    logic [31:0] data;
  } cpu_exp_t;
  cpu_exp_t cpu_q[$];

  always @(negedge clk) begin : cpu_mon
    cpu_exp_t e;
    if (!reset && cpu_ack) begin
      if (cpu_q.size() == 0) begin
        chk("cpu_ack_unexpected", 32'd1, 32'd0);
      end else begin
        e = cpu_q.pop_front();
        if (e.is_read) chk("cpu_rdata", cpu_rdata, e.data);
        else           chk("cpu_write_we", 32'(mem_we), 32'd1);
      end
    end
  end

  // ---------------- pixel order model ----------------
  logic [15:0] exp_idx = '0;

  always @(negedge clk) begin : pix_mon
    if (reset || frame_sync) begin
      exp_idx = '0;
    end else if (pix_rd && pix_valid) begin
      chk("pix_data", pix_data, exp_word(int'(exp_idx)));
      exp_idx = exp_idx + 16'd1;
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic cpu_drive(input logic we, input logic [15:0] a, input logic [31:0] d);
    cpu_exp_t e;
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = a;
    cpu_wdata = d;
    e.is_read = !we;
    if (we) begin
      shadow[int'(a)] = d;
      e.data = d;
    end else begin
      e.data = exp_word(int'(a));
    end
    cpu_q.push_back(e);
  endtask

  // ---------------- initial fill vector table ----------------
  typedef struct {
    logic        disp_en;
    logic        pix_rd;
    logic [15:0] exp_mem_addr;
    logic [15:0] exp_disp_addr;
    logic        exp_pix_valid;
    logic        exp_cpu_ack;
  } vec_t;
  vec_t vecs [11];

  initial begin
    int ack_at;
    bit valid_drop;
    bit found;

    for (int i = 0; i < 11; i++) begin
      vecs[i].disp_en       = 1'b1;
      vecs[i].pix_rd        = 1'b0;
      vecs[i].exp_mem_addr  = (i < 8) ? 16'(i) : 16'd0;
      vecs[i].exp_disp_addr = (i < 8) ? 16'(i) : 16'd8;
      vecs[i].exp_pix_valid = (i >= 2);
      vecs[i].exp_cpu_ack   = 1'b0;
    end

    reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    disp_en = 1'b0; frame_sync = 1'b0; pix_rd = 1'b0;
    repeat (2) @(posedge clk);
    smp();
    chk("rst_mem_addr",  32'(mem_addr), 32'd0);
    chk("rst_mem_we",    32'(mem_we), 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_cpu_ack",   32'(cpu_ack), 32'd0);
    chk("rst_cpu_rdata", cpu_rdata, 32'd0);
    chk("rst_pix_valid", 32'(pix_valid), 32'd0);
    chk("rst_pix_data",  pix_data, 32'd0);
    chk("rst_disp_addr", 32'(disp_addr), 32'd0);

    // Initial fill: eight back-to-back DISP fetches, then the FIFO is full.
    for (int i = 0; i < 11; i++) begin
      cyc();
      reset   = 1'b0;
      disp_en = vecs[i].disp_en;
      pix_rd  = vecs[i].pix_rd;
      smp();
      chk("fill_mem_addr",  32'(mem_addr),  32'(vecs[i].exp_mem_addr));
      chk("fill_disp_addr", 32'(disp_addr), 32'(vecs[i].exp_disp_addr));
      chk("fill_pix_valid", 32'(pix_valid), 32'(vecs[i].exp_pix_valid));
      chk("fill_cpu_ack",   32'(cpu_ack),   32'(vecs[i].exp_cpu_ack));
    end

    // CPU write is zero-wait, read acks one cycle later and is not re-granted.
    cyc();
    cpu_drive(1'b1, 16'h0100, 32'hDEADBEEF);
    smp();
    chk("wr_mem_we",    32'(mem_we), 32'd1);
    chk("wr_cpu_ack",   32'(cpu_ack), 32'd1);
    chk("wr_mem_addr",  32'(mem_addr), 32'h0100);
    chk("wr_mem_wdata", mem_wdata, 32'hDEADBEEF);
    cyc();
    cpu_req = 1'b0;
    smp();
    cyc();
    cpu_drive(1'b0, 16'h0100, 32'd0);
    smp();
    chk("rdN_cpu_ack",  32'(cpu_ack), 32'd0);
    chk("rdN_mem_addr", 32'(mem_addr), 32'h0100);
    chk("rdN_mem_we",   32'(mem_we), 32'd0);
    cyc();
    smp();
    chk("rdN1_cpu_ack",   32'(cpu_ack), 32'd1);
    chk("rdN1_cpu_rdata", cpu_rdata, 32'hDEADBEEF);
    chk("rdN1_no_regrant_addr", 32'(mem_addr), 32'd0);
    cyc();
    cpu_req = 1'b0;
    smp();

    // Drain to LOW_WATER with display fetches disabled; DISP then beats the CPU.
    for (int k = 0; k < 6; k++) begin
      cyc();
      disp_en = 1'b0;
      pix_rd  = 1'b1;
      smp();
    end
    chk("hold_disp_addr", 32'(disp_addr), 32'd8);
    cyc();
    pix_rd  = 1'b0;
    disp_en = 1'b1;
    cpu_drive(1'b1, 16'h0300, 32'h0BADF00D);
    smp();
    chk("urg_cpu_ack",  32'(cpu_ack), 32'd0);
    chk("urg_mem_addr", 32'(mem_addr), 32'd8);
    chk("urg_mem_we",   32'(mem_we), 32'd0);
    cyc();
    smp();
    chk("urg2_cpu_ack",  32'(cpu_ack), 32'd1);
    chk("urg2_mem_addr", 32'(mem_addr), 32'h0300);
    cyc();
    cpu_req = 1'b0;
    repeat (12) begin smp(); cyc(); end

    // Continuous popping from full with a CPU read held.
    pix_rd = 1'b1;
    cpu_drive(1'b0, 16'h0200, 32'd0);
    ack_at = -1;
    valid_drop = 1'b0;
    for (int j = 0; j < 30; j++) begin
      smp();
      if (!pix_valid) valid_drop = 1'b1;
      if (cpu_ack && ack_at < 0) ack_at = j;
      cyc();
      if (ack_at >= 0) cpu_req = 1'b0;
    end
    chk("stream_cpu_ack_cycle", 32'(ack_at), 32'd1);
    chk("stream_valid_drop", 32'(valid_drop), 32'd0);

    // Restart and stream through the address wrap.
    pix_rd = 1'b0;
    frame_sync = 1'b1;
    smp();
    chk("fs_mem_addr", 32'(mem_addr), 32'd0);
    chk("fs_mem_we",   32'(mem_we), 32'd0);
    cyc();
    frame_sync = 1'b0;
    pix_rd = 1'b1;
    disp_en = 1'b1;
    found = 1'b0;
    for (int j = 0; j < 70000; j++) begin
      smp();
      if (disp_addr == 16'hFFFF) begin
        found = 1'b1;
        break;
      end
      cyc();
    end
    chk("wrap_reached", 32'(found), 32'd1);
    chk("wrap_mem_addr_last", 32'(mem_addr), 32'h0000FFFF);
    cyc();
    smp();
    chk("wrap_disp_addr_zero", 32'(disp_addr), 32'd0);
    chk("wrap_mem_addr_zero",  32'(mem_addr), 32'd0);
    cyc();
    smp();
    chk("wrap_mem_addr_one", 32'(mem_addr), 32'd1);
    repeat (10) begin cyc(); smp(); end

    // frame_sync with a display read in flight and a simultaneous pop.
    cyc();
    frame_sync = 1'b1;
    smp();
    chk("fs2_no_disp_grant", 32'(mem_addr), 32'd0);
    cyc();
    frame_sync = 1'b0;
    pix_rd = 1'b0;
    disp_en = 1'b0;
    smp();
    chk("fs2_pix_valid", 32'(pix_valid), 32'd0);
    chk("fs2_disp_addr", 32'(disp_addr), 32'd0);
    chk("fs2_pix_data",  pix_data, 32'd0);
    cyc();
    smp();
    chk("fs2_discarded", 32'(pix_valid), 32'd0);
    cyc();
    disp_en = 1'b1;
    pix_rd = 1'b1;
    repeat (12) begin smp(); cyc(); end
    pix_rd = 1'b0;
    disp_en = 1'b0;
    repeat (2) begin smp(); cyc(); end

    // Reset while a CPU read is in flight: no ack.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0100;
    smp();
    chk("rstrd_mem_addr", 32'(mem_addr), 32'h0100);
    cyc();
    reset = 1'b1;
    smp();
    chk("rstrd_cpu_ack",   32'(cpu_ack), 32'd0);
    chk("rstrd_cpu_rdata", cpu_rdata, 32'd0);
    cyc();
    cpu_req = 1'b0;
    smp();
`ifdef VRAM_ARB_STATS_EN
    chk("rst_stat_cpu_wait",  stat_cpu_wait, 32'd0);
    chk("rst_stat_underflow", stat_underflow, 32'd0);
`endif
    cyc();
    reset = 1'b0;
    pix_rd = 1'b1;
    smp(); cyc(); smp(); cyc(); smp();
    cyc();
    pix_rd = 1'b0;
    smp();
`ifdef VRAM_ARB_STATS_EN
    chk("stat_underflow", stat_underflow, 32'd3);
`endif
    chk("underflow_pix_valid", 32'(pix_valid), 32'd0);

    // Fill, drain to two words, then hold DISP urgent for five cycles.
    cyc();
    disp_en = 1'b1;
    repeat (12) begin smp(); cyc(); end
    disp_en = 1'b0;
    pix_rd = 1'b1;
    repeat (6) begin smp(); cyc(); end
    disp_en = 1'b1;
    cpu_drive(1'b1, 16'h0400, 32'h11112222);
    for (int k = 0; k < 5; k++) begin
      if (k == 4) pix_rd = 1'b0;
      smp();
      chk("block_cpu_ack", 32'(cpu_ack), 32'd0);
      cyc();
    end
    smp();
    chk("block_release_ack", 32'(cpu_ack), 32'd1);
    cyc();
    cpu_req = 1'b0;
    smp();
`ifdef VRAM_ARB_STATS_EN
    chk("stat_cpu_wait", stat_cpu_wait, 32'd5);
`endif
    repeat (3) begin cyc(); smp(); end

    chk("cpu_q_empty", 32'(cpu_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
